memory_arbiter: RTL and testbench

//  Shares the single RAM port between the instruction fetch path (i*) and the data path (d*) of the MIPS core.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/memory_arbiter_if.sv | 41 ++++
 rtl/arb_timeout_ctr.sv | 28 ++
 rtl/memory_arbiter.sv | 151 +++++++++++++++
 tb/tb_memory_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory subsystem.
//   ramstate_t  : status reported by the RAM model each cycle
//   arbstate_t  : memory_arbiter grant state
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        D_GNT = 2'b01,
        I_GNT = 2'b10
    } arbstate_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the memory_arbiter signals: requester side (i*, d*) and RAM side.
// Ports: CLK, RST (clock and asynchronous active-high reset).
// Modports: arb (arbiter view), tb (driver/monitor view).
interface memory_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input logic CLK,
    input logic RST
);
    import cpu_types_pkg::*;

    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    ramstate_t         ramstate;
    logic              arb_err;

    modport arb (
        input  CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );

    modport tb (
        input  CLK, RST, iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err,
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate
    );

endinterface

// File: rtl/arb_timeout_ctr.sv
// Loadable saturating up-counter used for the grant timeout and the
// instruction starvation count.
// Ports: CLK, RST (async, active-high), load/load_val (synchronous load,
// wins over inc), inc (count up, holds at MAX), cnt (current value).
module arb_timeout_ctr #(
    parameter int unsigned W   = 8,
    parameter int unsigned MAX = 255
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single RAM port between instruction fetch (i*) and data (d*).
// Data has priority; after STARVE_LIM consecutive data grants with an
// instruction fetch waiting, the fetch is granted next. A grant ends on
// ACCESS (completion), ERROR or TIMEOUT cycles without ACCESS (abort with a
// one-cycle arb_err, requester keeps waiting), or when the owner drops its
// request. Every grant returns through IDLE.
// Ports: CLK/RST (async active-high); iREN/iaddr/iwait/iload instruction side;
// dREN/dWEN/daddr/dstore/dwait/dload data side; ramREN/ramWEN/ramaddr/
// ramstore/ramload/ramstate RAM side; arb_err abort pulse.
// Build option ARB_STATS_EN: adds igrant_cnt, dgrant_cnt, stall_cnt outputs.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
    output logic              arb_err
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       igrant_cnt,
    output logic [31:0]       dgrant_cnt,
    output logic [31:0]       stall_cnt
`endif
);
    arbstate_t  state, next_state;
    logic [3:0] starve_cnt;
    logic [7:0] tmo_cnt;
    logic       d_req, i_force, owner_req, done, fail;
    logic       starve_clr, starve_inc;

    assign d_req     = dREN | dWEN;
    assign i_force   = iREN && (starve_cnt == 4'(STARVE_LIM));
    assign owner_req = (state == D_GNT) ? d_req : iREN;
    assign done      = (state != IDLE) && owner_req && (ramstate == ACCESS);
    // Abort on ERROR, or on the grant cycle that would bring tmo_cnt to TIMEOUT.
    assign fail      = (state != IDLE) && owner_req &&
                       ((ramstate == ERROR) ||
                        ((ramstate != ACCESS) && (tmo_cnt == 8'(TIMEOUT - 1))));

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_req && !i_force) next_state = D_GNT;
                else if (iREN)         next_state = I_GNT;
            end
            default: begin
                if (!owner_req || done || fail) next_state = IDLE;
            end
        endcase
    end

    // Strobes follow the owner's live request so a dropped request
    // releases the RAM in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = iREN;
        dwait    = d_req;
        iload    = '0;
        dload    = '0;
        case (state)
            D_GNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                iwait    = 1'b1;
                dwait    = ~done;
                if (done) dload = ramload;
            end
            I_GNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                dwait   = 1'b1;
                iwait   = ~done;
                if (done) iload = ramload;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            arb_err <= 1'b0;
        end else begin
            state   <= next_state;
            arb_err <= fail;
        end
    end

    assign starve_clr = (state == IDLE) && (!iREN || (next_state == I_GNT));
    assign starve_inc = (state == IDLE) && (next_state == D_GNT) && iREN;

    arb_timeout_ctr #(.W(4), .MAX(STARVE_LIM)) u_starve (
        .CLK      (CLK),
        .RST      (RST),
        .load     (starve_clr),
        .load_val ('0),
        .inc      (starve_inc),
        .cnt      (starve_cnt)
    );

    // Held at zero through IDLE, so each grant starts counting from zero.
    arb_timeout_ctr #(.W(8), .MAX(TIMEOUT)) u_tmo (
        .CLK      (CLK),
        .RST      (RST),
        .load     (state == IDLE),
        .load_val ('0),
        .inc      ((state != IDLE) && (ramstate != ACCESS)),
        .cnt      (tmo_cnt)
    );

`ifdef ARB_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            igrant_cnt <= '0;
            dgrant_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (done && (state == I_GNT)) igrant_cnt <= igrant_cnt + 32'd1;
            if (done && (state == D_GNT)) dgrant_cnt <= dgrant_cnt + 32'd1;
            if ((iwait && iREN) || (dwait && d_req)) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE_LIM = 4;
    localparam int TIMEOUT    = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus (.CLK(CLK), .RST(RST));

`ifdef ARB_STATS_EN
    logic [31:0] s_i, s_d, s_s;
`endif

    memory_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_LIM(STARVE_LIM),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (bus.iREN),
        .iaddr    (bus.iaddr),
        .iwait    (bus.iwait),
        .iload    (bus.iload),
        .dREN     (bus.dREN),
        .dWEN     (bus.dWEN),
        .daddr    (bus.daddr),
        .dstore   (bus.dstore),
        .dwait    (bus.dwait),
        .dload    (bus.dload),
        .ramREN   (bus.ramREN),
        .ramWEN   (bus.ramWEN),
        .ramaddr  (bus.ramaddr),
        .ramstore (bus.ramstore),
        .ramload  (bus.ramload),
        .ramstate (bus.ramstate),
        .arb_err  (bus.arb_err)
`ifdef ARB_STATS_EN
        ,
        .igrant_cnt(s_i),
        .dgrant_cnt(s_d),
        .stall_cnt (s_s)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: who owns the RAM (0 none, 1 data, 2 instr), how many
    // grant cycles passed without ACCESS, how many data grants in a row were
    // given while a fetch waited, and whether an abort happened last cycle.
    int m_own    = 0;
    int m_age    = 0;
    int m_streak = 0;
    bit m_err    = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_own    <= 0;
            m_age    <= 0;
            m_streak <= 0;
            m_err    <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (m_own == 0) begin
                if ((bus.dREN || bus.dWEN) && !(bus.iREN && m_streak == STARVE_LIM)) begin
                    m_own <= 1;
                    m_age <= 0;
                    if (bus.iREN && m_streak < STARVE_LIM) m_streak <= m_streak + 1;
                end else if (bus.iREN) begin
                    m_own    <= 2;
                    m_age    <= 0;
                    m_streak <= 0;
                end
                if (!bus.iREN) m_streak <= 0;
            end else if (!((m_own == 1) ? (bus.dREN || bus.dWEN) : bus.iREN)) begin
                m_own <= 0;
            end else if (bus.ramstate == ACCESS) begin
                m_own <= 0;
            end else if (bus.ramstate == ERROR || m_age + 1 == TIMEOUT) begin
                m_own <= 0;
                m_err <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge CLK) begin
        logic        e_rr, e_rw, e_iw, e_dw;
        logic [31:0] e_a, e_s, e_il, e_dl;
        e_rr = 1'b0; e_rw = 1'b0; e_a = '0; e_s = '0; e_il = '0; e_dl = '0;
        e_iw = bus.iREN;
        e_dw = bus.dREN | bus.dWEN;
        if (m_own == 1) begin
            e_rw = bus.dWEN;
            e_rr = bus.dREN & ~bus.dWEN;
            e_a  = bus.daddr;
            e_s  = bus.dstore;
            e_iw = 1'b1;
            e_dw = 1'b1;
            if ((bus.dREN || bus.dWEN) && bus.ramstate == ACCESS) begin
                e_dw = 1'b0;
                e_dl = bus.ramload;
            end
        end else if (m_own == 2) begin
            e_rr = bus.iREN;
            e_a  = bus.iaddr;
            e_iw = 1'b1;
            e_dw = 1'b1;
            if (bus.iREN && bus.ramstate == ACCESS) begin
                e_iw = 1'b0;
                e_il = bus.ramload;
            end
        end
        chk("m_ramREN",   bus.ramREN,   e_rr);
        chk("m_ramWEN",   bus.ramWEN,   e_rw);
        chk("m_ramaddr",  bus.ramaddr,  e_a);
        chk("m_ramstore", bus.ramstore, e_s);
        chk("m_iwait",    bus.iwait,    e_iw);
        chk("m_dwait",    bus.dwait,    e_dw);
        chk("m_iload",    bus.iload,    e_il);
        chk("m_dload",    bus.dload,    e_dl);
        chk("m_arb_err",  bus.arb_err,  m_err);
    end

    task automatic step(input logic i_r, input logic [31:0] i_a,
                        input logic d_r, input logic d_w,
                        input logic [31:0] d_a, input logic [31:0] d_s,
                        input ramstate_t r_s, input logic [31:0] r_l);
        @(posedge CLK);
        #1;
        bus.iREN = i_r; bus.iaddr = i_a;
        bus.dREN = d_r; bus.dWEN = d_w; bus.daddr = d_a; bus.dstore = d_s;
        bus.ramstate = r_s; bus.ramload = r_l;
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, FREE, '0);
    endtask

    initial begin
        bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.daddr = '0; bus.dstore = '0; bus.ramstate = FREE; bus.ramload = '0;
        #2;
        chk("rst_ramREN",  bus.ramREN,  1'b0);
        chk("rst_ramWEN",  bus.ramWEN,  1'b0);
        chk("rst_ramaddr", bus.ramaddr, 32'h0);
        chk("rst_iwait",   bus.iwait,   1'b0);
        chk("rst_dwait",   bus.dwait,   1'b0);
        chk("rst_arb_err", bus.arb_err, 1'b0);
        idle_step();
        RST = 1'b0;
        idle_step();

        // 1: instruction fetch, two BUSY then ACCESS
        step(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, BUSY, 32'hBAD00001);
        chk("t1_c1_iwait", bus.iwait, 1'b1);
        chk("t1_c1_ramREN", bus.ramREN, 1'b0);
        step(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, BUSY, 32'hBAD00001);
        chk("t1_c2_ramREN", bus.ramREN, 1'b1);
        chk("t1_c2_ramaddr", bus.ramaddr, 32'h40);
        chk("t1_c2_iload", bus.iload, 32'h0);
        step(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, ACCESS, 32'h12345678);
        chk("t1_c3_iwait", bus.iwait, 1'b0);
        chk("t1_c3_iload", bus.iload, 32'h12345678);
        chk("t1_c3_ramWEN", bus.ramWEN, 1'b0);
        idle_step();

        // 2: simultaneous write and fetch, data first
        step(1'b1, 32'h80, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, FREE, '0);
        chk("t2_idle_ramWEN", bus.ramWEN, 1'b0);
        step(1'b1, 32'h80, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, BUSY, '0);
        chk("t2_ramWEN", bus.ramWEN, 1'b1);
        chk("t2_ramstore", bus.ramstore, 32'hDEADBEEF);
        chk("t2_ramaddr", bus.ramaddr, 32'h100);
        step(1'b1, 32'h80, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, ACCESS, '0);
        chk("t2_dwait", bus.dwait, 1'b0);
        chk("t2_iwait", bus.iwait, 1'b1);
        step(1'b1, 32'h80, 1'b0, 1'b0, '0, '0, FREE, '0);
        chk("t2_gap_ramREN", bus.ramREN, 1'b0);
        step(1'b1, 32'h80, 1'b0, 1'b0, '0, '0, BUSY, '0);
        chk("t2_igrant_addr", bus.ramaddr, 32'h80);
        step(1'b1, 32'h80, 1'b0, 1'b0, '0, '0, ACCESS, 32'hCAFE0001);
        chk("t2_iload", bus.iload, 32'hCAFE0001);
        idle_step();

        // 3: starvation guard, fifth grant goes to the fetch
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 32'h200, 1'b1, 1'b0, 32'h300 + 32'(4 * k), '0, FREE, '0);
            step(1'b1, 32'h200, 1'b1, 1'b0, 32'h300 + 32'(4 * k), '0, ACCESS, 32'h1000 + 32'(k));
            chk("t3_d_addr", bus.ramaddr, 32'h300 + 32'(4 * k));
            chk("t3_d_dload", bus.dload, 32'h1000 + 32'(k));
        end
        step(1'b1, 32'h200, 1'b1, 1'b0, 32'h310, '0, FREE, '0);
        step(1'b1, 32'h200, 1'b1, 1'b0, 32'h310, '0, ACCESS, 32'hAAAA0005);
        chk("t3_5th_addr", bus.ramaddr, 32'h200);
        chk("t3_5th_iwait", bus.iwait, 1'b0);
        chk("t3_5th_dwait", bus.dwait, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 32'h310, '0, FREE, '0);
        step(1'b0, '0, 1'b1, 1'b0, 32'h310, '0, ACCESS, 32'h5);
        chk("t3_last_dwait", bus.dwait, 1'b0);
        idle_step();

        // 4: RAM stuck BUSY, abort after TIMEOUT grant cycles
        step(1'b0, '0, 1'b1, 1'b0, 32'h500, '0, BUSY, '0);
        for (int g = 1; g <= TIMEOUT; g++) begin
            step(1'b0, '0, 1'b1, 1'b0, 32'h500, '0, BUSY, '0);
            chk("t4_grant_ramREN", bus.ramREN, 1'b1);
            chk("t4_grant_arb_err", bus.arb_err, 1'b0);
        end
        step(1'b0, '0, 1'b1, 1'b0, 32'h500, '0, BUSY, '0);
        chk("t4_abort_arb_err", bus.arb_err, 1'b1);
        chk("t4_abort_ramREN", bus.ramREN, 1'b0);
        chk("t4_abort_dwait", bus.dwait, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 32'h500, '0, BUSY, '0);
        chk("t4_regrant_ramREN", bus.ramREN, 1'b1);
        chk("t4_regrant_arb_err", bus.arb_err, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 32'h500, '0, ACCESS, 32'h9);
        chk("t4_done_dwait", bus.dwait, 1'b0);
        idle_step();

        // 5: reset mid-write clears strobes and starvation count
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h700, 1'b0, 1'b1, 32'h600, 32'h55 + 32'(k), FREE, '0);
            step(1'b1, 32'h700, 1'b0, 1'b1, 32'h600, 32'h55 + 32'(k), ACCESS, '0);
            chk("t5_pre_dwait", bus.dwait, 1'b0);
        end
        step(1'b1, 32'h700, 1'b0, 1'b1, 32'h600, 32'h58, FREE, '0);
        step(1'b1, 32'h700, 1'b0, 1'b1, 32'h600, 32'h58, BUSY, '0);
        chk("t5_pre_ramWEN", bus.ramWEN, 1'b1);
        #1 RST = 1'b1;
        #1;
        chk("t5_rst_ramWEN", bus.ramWEN, 1'b0);
        chk("t5_rst_ramaddr", bus.ramaddr, 32'h0);
        chk("t5_rst_ramstore", bus.ramstore, 32'h0);
        chk("t5_rst_arb_err", bus.arb_err, 1'b0);
        step(1'b1, 32'h700, 1'b0, 1'b1, 32'h600, 32'h58, BUSY, '0);
        RST = 1'b0;
        step(1'b1, 32'h700, 1'b0, 1'b1, 32'h600, 32'h58, BUSY, '0);
        chk("t5_post_ramWEN", bus.ramWEN, 1'b1);
        chk("t5_post_ramREN", bus.ramREN, 1'b0);
        step(1'b1, 32'h700, 1'b0, 1'b1, 32'h600, 32'h58, ACCESS, '0);
        chk("t5_post_dwait", bus.dwait, 1'b0);
        idle_step();

        // 6: ERROR during instruction grant
        step(1'b1, 32'h900, 1'b0, 1'b0, '0, '0, FREE, '0);
        step(1'b1, 32'h900, 1'b0, 1'b0, '0, '0, ERROR, '0);
        chk("t6_err_ramREN", bus.ramREN, 1'b1);
        chk("t6_err_iwait", bus.iwait, 1'b1);
        step(1'b1, 32'h900, 1'b0, 1'b0, '0, '0, FREE, '0);
        chk("t6_arb_err", bus.arb_err, 1'b1);
        chk("t6_idle_iwait", bus.iwait, 1'b1);
        step(1'b1, 32'h900, 1'b0, 1'b0, '0, '0, BUSY, '0);
        chk("t6_regrant_ramREN", bus.ramREN, 1'b1);
        chk("t6_regrant_arb_err", bus.arb_err, 1'b0);
        step(1'b1, 32'h900, 1'b0, 1'b0, '0, '0, ACCESS, 32'h77);
        chk("t6_iload", bus.iload, 32'h77);
        idle_step();

        // 7: read+write together acts as write; owner drops mid-grant
        step(1'b0, '0, 1'b1, 1'b1, 32'hA00, 32'h11, FREE, '0);
        step(1'b0, '0, 1'b1, 1'b1, 32'hA00, 32'h11, BUSY, '0);
        chk("t7_rw_ramWEN", bus.ramWEN, 1'b1);
        chk("t7_rw_ramREN", bus.ramREN, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 32'hA00, 32'h11, BUSY, '0);
        chk("t7_drop_ramWEN", bus.ramWEN, 1'b0);
        idle_step();
        chk("t7_drop_arb_err", bus.arb_err, 1'b0);
        idle_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
